// File: rtl/bp_master.sv
// bp_master: BytePipe initiator. Takes one read or write request, sends
// the command byte (plus a data byte for writes), then forwards the
// responder's reply bytes to a local consumer with a last flag.
// Optional feature macro: BPMASTER_BURST_EN. When it is defined, a read
// with a non-zero burst length first programs the responder's burst
// length register (address 0) and then collects N+1 reply bytes.
module bp_master #(
  parameter int TXN_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [6:0]           i_req_addr,
  input  logic [7:0]           i_req_wrData,
  input  logic [7:0]           i_req_burstLen,
  output logic [7:0]           o_bp_data,
  output logic                 o_bp_valid,
  input  logic                 i_bp_ready,
  input  logic [7:0]           i_bp_data,
  input  logic                 i_bp_valid,
  output logic                 o_bp_ready,
  output logic [7:0]           o_rsp_data,
  output logic                 o_rsp_valid,
  output logic                 o_rsp_last,
  input  logic                 i_rsp_ready,
  output logic                 o_busy,
  output logic [TXN_CNT_W-1:0] o_txnCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_RSP  = 3'd3,
    S_BCMD = 3'd4,
    S_BLEN = 3'd5,
    S_BACK = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr;
  logic [6:0]            r_addr;
  logic [7:0]            r_wrData;
  logic [7:0]            r_rspRemain;
  logic [TXN_CNT_W-1:0]  r_txnCount;
  logic                  w_capture;
  logic                  w_accept;
  logic                  w_done;
  logic [7:0]            w_remainLoad;

  assign w_capture = (r_state == S_IDLE) && i_req_valid;
  // A reply byte is consumed only when both the responder and consumer agree.
  assign w_accept  = (r_state == S_RSP) && i_bp_valid && i_rsp_ready;
  assign w_done    = w_accept && (r_rspRemain == 8'd0);

`ifdef BPMASTER_BURST_EN
  logic [7:0] r_burstLen;
  logic       w_burst;

  assign w_burst      = !i_req_wr && (i_req_burstLen != 8'd0);
  assign w_remainLoad = w_burst ? i_req_burstLen : 8'd0;

  // Burst length is kept alongside the other captured request fields.
  always_ff @(posedge i_clk) begin
    if (i_cg && w_capture) r_burstLen <= i_req_burstLen;
  end
`else
  logic w_unused_burstLen;
  assign w_unused_burstLen = ^i_req_burstLen;
  assign w_remainLoad      = 8'd0;
`endif

  // Captured request fields; deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_cg && w_capture) begin
      r_wr     <= i_req_wr;
      r_addr   <= i_req_addr;
      r_wrData <= i_req_wrData;
    end
  end

  // State register, reply-byte countdown and completed-transaction counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rspRemain <= 8'd0;
      r_txnCount  <= '0;
    end else if (i_cg) begin
      r_state <= w_next;
      if (w_capture)     r_rspRemain <= w_remainLoad;
      else if (w_accept) r_rspRemain <= r_rspRemain - 8'd1;
      if (w_done)        r_txnCount  <= r_txnCount + 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
`ifdef BPMASTER_BURST_EN
          w_next = w_burst ? S_BCMD : S_CMD;
`else
          w_next = S_CMD;
`endif
        end
      end
      S_CMD:  if (i_bp_ready) w_next = r_wr ? S_DATA : S_RSP;
      S_DATA: if (i_bp_ready) w_next = S_RSP;
      S_RSP:  if (w_done)     w_next = S_IDLE;
`ifdef BPMASTER_BURST_EN
      S_BCMD: if (i_bp_ready) w_next = S_BLEN;
      S_BLEN: if (i_bp_ready) w_next = S_BACK;
      S_BACK: if (i_bp_valid) w_next = S_CMD;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; o_bp_valid comes from state only, never from i_bp_ready.
  always_comb begin
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    o_bp_valid  = 1'b0;
    o_bp_data   = 8'd0;
    o_bp_ready  = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_data  = 8'd0;
    o_rsp_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      S_CMD: begin
        o_bp_valid = 1'b1;
        o_bp_data  = {r_wr, r_addr};
      end
      S_DATA: begin
        o_bp_valid = 1'b1;
        o_bp_data  = r_wrData;
      end
      S_RSP: begin
        o_bp_ready  = i_rsp_ready;
        o_rsp_valid = i_bp_valid;
        o_rsp_data  = i_bp_data;
        o_rsp_last  = (r_rspRemain == 8'd0);
      end
`ifdef BPMASTER_BURST_EN
      S_BCMD: begin
        o_bp_valid = 1'b1;
        o_bp_data  = 8'h80;
      end
      S_BLEN: begin
        o_bp_valid = 1'b1;
        o_bp_data  = r_burstLen;
      end
      // The read-back of the burst length write is swallowed here.
      S_BACK: o_bp_ready = 1'b1;
`endif
      default: ;
    endcase
  end

  assign o_txnCount = r_txnCount;

endmodule

// File: tb/tb_bp_master.sv
// Directed bench for bp_master. The counter is built narrow so that the
// wrap from all-ones to zero can be reached in a short run.
module tb_bp_master;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, cg;
  logic          req_valid, req_wr;
  logic [6:0]    req_addr;
  logic [7:0]    req_wrData, req_burstLen;
  logic          req_ready;
  logic [7:0]    bp_data_o, bp_data_i;
  logic          bp_valid_o, bp_ready_i, bp_valid_i, bp_ready_o;
  logic [7:0]    rsp_data;
  logic          rsp_valid, rsp_last, rsp_ready, busy;
  logic [CW-1:0] txn;

  int n_vec = 0;
  int n_err = 0;

  bp_master #(.TXN_CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_wrData(req_wrData), .i_req_burstLen(req_burstLen),
    .o_bp_data(bp_data_o), .o_bp_valid(bp_valid_o), .i_bp_ready(bp_ready_i),
    .i_bp_data(bp_data_i), .i_bp_valid(bp_valid_i), .o_bp_ready(bp_ready_o),
    .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid), .o_rsp_last(rsp_last),
    .i_rsp_ready(rsp_ready), .o_busy(busy), .o_txnCount(txn)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cg = 1'b1; req_valid = 0; req_wr = 0; req_addr = 0;
    req_wrData = 0; req_burstLen = 0; bp_ready_i = 0; bp_data_i = 0;
    bp_valid_i = 0; rsp_ready = 0;
    #3;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if ({bp_valid_o, rsp_valid, rsp_last, bp_ready_o} !== 4'b0) begin n_err++; $display("FAIL rst_outs got %b want 0000", {bp_valid_o, rsp_valid, rsp_last, bp_ready_o}); end
    n_vec++; if (txn !== '0) begin n_err++; $display("FAIL rst_txn got %0d want 0", txn); end
    cyc; cyc; rst = 1'b0; cyc;
  endtask

  task automatic test_read;
    req_valid = 1; req_wr = 0; req_addr = 7'h05; #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_req_ready got %b want 1", req_ready); end
    cyc; req_valid = 0; bp_ready_i = 1; #1;
    n_vec++; if ({bp_valid_o, bp_data_o} !== {1'b1, 8'h05}) begin n_err++; $display("FAIL rd_cmd got %b/%h want 1/05", bp_valid_o, bp_data_o); end
    n_vec++; if ({busy, req_ready} !== 2'b10) begin n_err++; $display("FAIL rd_busy got %b want 10", {busy, req_ready}); end
    cyc; bp_ready_i = 0; bp_valid_i = 1; bp_data_i = 8'h0A; rsp_ready = 1; #1;
    n_vec++; if ({rsp_valid, rsp_last, rsp_data} !== {2'b11, 8'h0A}) begin n_err++; $display("FAIL rd_rsp got %b%b/%h want 11/0a", rsp_valid, rsp_last, rsp_data); end
    n_vec++; if ({bp_valid_o, bp_ready_o} !== 2'b01) begin n_err++; $display("FAIL rd_rsp_hs got %b want 01", {bp_valid_o, bp_ready_o}); end
    cyc; bp_valid_i = 0; #1;
    n_vec++; if ({req_ready, txn} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL rd_done got %b/%0d want 1/1", req_ready, txn); end
  endtask

  task automatic test_write;
    req_valid = 1; req_wr = 1; req_addr = 7'h09; req_wrData = 8'h03;
    cyc; req_valid = 0; bp_ready_i = 1; #1;
    n_vec++; if (bp_data_o !== 8'h89) begin n_err++; $display("FAIL wr_cmd got %h want 89", bp_data_o); end
    cyc; #1;
    n_vec++; if ({bp_valid_o, bp_data_o, req_ready} !== {1'b1, 8'h03, 1'b0}) begin n_err++; $display("FAIL wr_data got %b/%h/%b want 1/03/0", bp_valid_o, bp_data_o, req_ready); end
    cyc; bp_ready_i = 0; bp_valid_i = 1; bp_data_i = 8'h03; rsp_ready = 1; #1;
    n_vec++; if ({rsp_valid, rsp_last, rsp_data, req_ready} !== {2'b11, 8'h03, 1'b0}) begin n_err++; $display("FAIL wr_rsp got %b%b/%h/%b want 11/03/0", rsp_valid, rsp_last, rsp_data, req_ready); end
    cyc; bp_valid_i = 0; #1;
    n_vec++; if ({req_ready, txn} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL wr_done got %b/%0d want 1/2", req_ready, txn); end
  endtask

  task automatic test_backpressure;
    req_valid = 1; req_wr = 0; req_addr = 7'h05;
    cyc; req_valid = 0; bp_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if ({bp_valid_o, bp_data_o, bp_ready_o} !== {1'b1, 8'h05, 1'b0}) begin n_err++; $display("FAIL bpr_cmd_hold%0d got %b/%h/%b want 1/05/0", i, bp_valid_o, bp_data_o, bp_ready_o); end
      cyc;
    end
    bp_ready_i = 1; cyc;
    bp_ready_i = 0; bp_valid_i = 1; bp_data_i = 8'h33; rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({bp_ready_o, busy, bp_valid_o} !== 3'b010) begin n_err++; $display("FAIL bpr_rsp_hold%0d got %b want 010", i, {bp_ready_o, busy, bp_valid_o}); end
      cyc;
    end
    rsp_ready = 1; #1;
    n_vec++; if ({bp_ready_o, rsp_valid, rsp_last, rsp_data} !== {3'b111, 8'h33}) begin n_err++; $display("FAIL bpr_rsp got %b%b%b/%h want 111/33", bp_ready_o, rsp_valid, rsp_last, rsp_data); end
    cyc; #1;
    // Responder still asserting valid in IDLE must not produce a second byte.
    n_vec++; if ({rsp_valid, bp_ready_o, txn} !== {2'b00, 3'd3}) begin n_err++; $display("FAIL bpr_nodup got %b%b/%0d want 00/3", rsp_valid, bp_ready_o, txn); end
    bp_valid_i = 0;
  endtask

  task automatic test_empty_fifo;
    req_valid = 1; req_wr = 0; req_addr = 7'h05;
    cyc; req_valid = 0; bp_ready_i = 1;
    cyc; bp_ready_i = 0; rsp_ready = 1; bp_valid_i = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_vec++; if ({busy, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL empty_wait%0d got %b want 10", i, {busy, rsp_valid}); end
      cyc;
    end
    bp_valid_i = 1; bp_data_i = 8'h7E; #1;
    n_vec++; if ({rsp_valid, rsp_last, rsp_data} !== {2'b11, 8'h7E}) begin n_err++; $display("FAIL empty_rsp got %b%b/%h want 11/7e", rsp_valid, rsp_last, rsp_data); end
    cyc; bp_valid_i = 0; #1;
    n_vec++; if ({busy, txn} !== {1'b0, 3'd4}) begin n_err++; $display("FAIL empty_done got %b/%0d want 0/4", busy, txn); end
  endtask

  task automatic test_reset_mid;
    req_valid = 1; req_wr = 1; req_addr = 7'h09; req_wrData = 8'h03;
    cyc; req_valid = 0; bp_ready_i = 1;
    cyc; bp_ready_i = 0; #1;
    n_vec++; if (bp_data_o !== 8'h03) begin n_err++; $display("FAIL rmid_in_data got %h want 03", bp_data_o); end
    #1 rst = 1; #1;
    n_vec++; if ({bp_valid_o, req_ready, txn} !== {2'b01, 3'd0}) begin n_err++; $display("FAIL rmid got %b%b/%0d want 01/0", bp_valid_o, req_ready, txn); end
    cyc; rst = 0; cyc;
  endtask

  task automatic test_clock_gate;
    req_valid = 1; req_wr = 0; req_addr = 7'h05;
    cyc; req_valid = 0; cg = 0; bp_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      n_vec++; if ({bp_valid_o, bp_data_o} !== {1'b1, 8'h05}) begin n_err++; $display("FAIL cg_hold%0d got %b/%h want 1/05", i, bp_valid_o, bp_data_o); end
    end
    cg = 1; cyc; bp_ready_i = 0; bp_valid_i = 1; bp_data_i = 8'h55; rsp_ready = 1; #1;
    n_vec++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h55}) begin n_err++; $display("FAIL cg_rsp got %b/%h want 1/55", rsp_valid, rsp_data); end
    cyc; bp_valid_i = 0; #1;
    n_vec++; if (txn !== 3'd1) begin n_err++; $display("FAIL cg_txn got %0d want 1", txn); end
  endtask

  // Seven reads with request held high: each takes exactly 3 cycles, and
  // the counter goes 1 -> 7 -> 0 (wrap at CW bits).
  task automatic test_back_to_back;
    req_valid = 1; req_wr = 0; bp_ready_i = 1; bp_valid_i = 1; rsp_ready = 1;
    for (int i = 0; i < 7; i++) begin
      req_addr = 7'(i + 1); bp_data_i = 8'(8'hC0 + i); #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle%0d got %b want 1", i, req_ready); end
      cyc;
      n_vec++; if (bp_data_o !== 8'(i + 1)) begin n_err++; $display("FAIL b2b_cmd%0d got %h want %h", i, bp_data_o, 8'(i + 1)); end
      cyc;
      n_vec++; if ({rsp_valid, rsp_last, rsp_data} !== {2'b11, 8'(8'hC0 + i)}) begin n_err++; $display("FAIL b2b_rsp%0d got %b%b/%h want 11/%h", i, rsp_valid, rsp_last, rsp_data, 8'(8'hC0 + i)); end
      cyc;
    end
    req_valid = 0; bp_valid_i = 0; bp_ready_i = 0; #1;
    n_vec++; if ({req_ready, txn} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL b2b_wrap got %b/%0d want 1/0", req_ready, txn); end
  endtask

`ifdef BPMASTER_BURST_EN
  task automatic test_burst;
    req_valid = 1; req_wr = 0; req_addr = 7'h01; req_burstLen = 8'd3;
    cyc; req_valid = 0; req_burstLen = 0; bp_ready_i = 1; #1;
    n_vec++; if ({bp_valid_o, bp_data_o} !== {1'b1, 8'h80}) begin n_err++; $display("FAIL bst_bcmd got %b/%h want 1/80", bp_valid_o, bp_data_o); end
    cyc;
    n_vec++; if (bp_data_o !== 8'h03) begin n_err++; $display("FAIL bst_blen got %h want 03", bp_data_o); end
    cyc; bp_ready_i = 0; bp_valid_i = 1; bp_data_i = 8'hAA; rsp_ready = 1; #1;
    n_vec++; if ({bp_ready_o, rsp_valid, bp_valid_o} !== 3'b100) begin n_err++; $display("FAIL bst_back got %b want 100", {bp_ready_o, rsp_valid, bp_valid_o}); end
    cyc; bp_valid_i = 0; bp_ready_i = 1; #1;
    n_vec++; if (bp_data_o !== 8'h01) begin n_err++; $display("FAIL bst_cmd got %h want 01", bp_data_o); end
    cyc; bp_ready_i = 0; bp_valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      bp_data_i = 8'(8'h10 + k); #1;
      n_vec++; if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, (k == 3), 8'(8'h10 + k)}) begin n_err++; $display("FAIL bst_rsp%0d got %b%b/%h want 1%b/%h", k, rsp_valid, rsp_last, rsp_data, (k == 3), 8'(8'h10 + k)); end
      cyc;
    end
    bp_valid_i = 0; #1;
    n_vec++; if ({req_ready, txn} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL bst_done got %b/%0d want 1/1", req_ready, txn); end
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_write;
    test_backpressure;
    test_empty_fifo;
    test_reset_mid;
    test_clock_gate;
    test_back_to_back;
`ifdef BPMASTER_BURST_EN
    test_burst;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_master.md
Name: bp_master

Overview:
- BytePipe initiator; drives register-access transactions into a BytePipe register responder (e.g. over USB or a direct on-chip link).
- Accepts one request per transaction (read, or write), serialises it into command/data bytes and collects the response byte(s).
- Forwards response bytes to a local consumer with a last flag.
- Used by on-chip test harnesses and loopback benches to exercise the register map without a host.

Parameters:
- TXN_CNT_W, 16, width of the completed-transaction counter o_txnCount (wraps).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_cg  input  1  clock gate; when low, all state holds.
- i_req_valid  input  1  request valid.
- o_req_ready  output  1  request ready; high only in IDLE.
- i_req_wr  input  1  1=write, 0=read.
- i_req_addr  input  7  register address (1..127; 0 reserved for burst length).
- i_req_wrData  input  8  write data, ignored for reads.
- i_req_burstLen  input  8  extra read bytes; only used with BPMASTER_BURST_EN, else ignored.
- o_bp_data  output  8  command/data byte to responder.
- o_bp_valid  output  1  byte valid to responder.
- i_bp_ready  input  1  responder ready.
- i_bp_data  input  8  response byte from responder.
- i_bp_valid  input  1  response valid.
- o_bp_ready  output  1  response ready.
- o_rsp_data  output  8  response byte to consumer.
- o_rsp_valid  output  1  response valid.
- o_rsp_last  output  1  final byte of the transaction.
- i_rsp_ready  input  1  consumer ready.
- o_busy  output  1  high in every state except IDLE.
- o_txnCount  output  TXN_CNT_W  count of completed transactions.

Behaviour:
- Protocol:
  - Command byte = {wr, addr[6:0]}.
  - Write: cmd, then one data byte. The responder returns exactly 1 byte, which is the read-back of the written register.
  - Read: cmd only. The responder returns exactly 1 byte.
  - Byte-level handshake: a byte transfers when valid && ready on the same edge.
- FSM (registered, 2-bit or wider state):
  - IDLE: o_req_ready=1. On i_req_valid, capture wr/addr/wrData/burstLen and go to CMD.
  - CMD: o_bp_valid=1, o_bp_data=cmd byte. On i_bp_ready, go to DATA if write, else RSP.
  - DATA: o_bp_valid=1, o_bp_data=wrData. On i_bp_ready, go to RSP.
  - RSP:
    - o_bp_ready = i_rsp_ready (straight through); o_rsp_valid = i_bp_valid; o_rsp_data = i_bp_data.
    - o_rsp_last = (rspRemain == 0).
    - Each accepted byte decrements the 8-bit rspRemain.
    - On the accepted last byte: increment o_txnCount, go to IDLE.
- rspRemain:
  - Loaded with 0 on capture.
  - With BPMASTER_BURST_EN, see Optional Feature.
- o_bp_valid must not depend combinationally on i_bp_ready; it is driven only from state.
- While the responder withholds valid (e.g. empty FIFO read), the block waits in RSP indefinitely. There is no timeout.
- Back-to-back requests: a request is accepted in IDLE on the cycle after the last response byte. Minimum read turnaround is 3 cycles (IDLE→CMD→RSP→IDLE) with the responder immediately ready and valid.
- Reset values:
  - state=IDLE, so o_req_ready=1.
  - o_busy=0, o_bp_valid=0, o_rsp_valid=0, o_rsp_last=0, o_bp_ready=0, o_txnCount=0.
  - Captured fields are unreset.
- Reset mid-transaction returns to IDLE immediately, with no flush of the responder. Responder resync is the system's responsibility.
- o_txnCount wraps from all-ones to 0.
- i_cg low freezes all flops. Outputs stay consistent with the held state.

Optional Feature:
- Macro BPMASTER_BURST_EN.
- Defined, for a read with i_req_burstLen=N where N≠0:
  - FSM inserts BCMD (sends 0x80, write to addr 0) → BLEN (sends N) → BACK.
  - BACK: o_bp_ready=1; the single read-back byte is accepted and discarded, with o_rsp_valid=0.
  - Then proceeds to CMD for the real read.
  - The responder returns N+1 bytes, so rspRemain is loaded with N.
  - o_rsp_last is asserted only on byte N+1.
  - Writes ignore burstLen.
- Undefined: burstLen is ignored, the BCMD/BLEN/BACK states do not exist, and every transaction returns exactly 1 byte.

Test Plan:
- Read addr 0x05, responder returns 0x0A → o_bp_data sequence {0x05}; one o_rsp byte 0x0A with last=1; o_txnCount=1.
- Write addr 0x09, data 0x03 → o_bp_data {0x89,0x03}; readback 0x03 forwarded with last=1; o_req_ready low until then.
- Backpressure: i_bp_ready low 4 cycles in CMD, then i_rsp_ready low 3 cycles in RSP → o_bp_data held at 0x05; o_bp_ready low throughout; no byte lost or duplicated.
- Empty-FIFO read (i_bp_valid low 20 cycles) → o_busy=1, o_rsp_valid=0 throughout; completes normally when 0x7E arrives.
- Reset asserted in DATA → same-cycle async return to IDLE: o_bp_valid=0, o_req_ready=1, o_txnCount=0.
- BPMASTER_BURST_EN, read addr 1, burstLen=3 → o_bp_data {0x80,0x03,0x01}; ack byte discarded; 4 response bytes forwarded with last on the 4th.
